// File: rtl/apa102_in_if.sv
// Write-side sram_bus port: one word per write_strobe pulse.
interface apa102_in_if #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16
);
    logic [ADDRESS_BUS_WIDTH-1:0] write_address;
    logic [DATA_BUS_WIDTH-1:0]    write_data;
    logic                         write_strobe;

    modport master (output write_address, output write_data, output write_strobe);
    modport slave  (input  write_address, input  write_data, input  write_strobe);
endinterface

// File: rtl/apa102_in.sv
// APA102 receiver: syncs an external data/clock pair, frames start and LED
// frames, and writes each LED frame as two 16-bit words to the sram_bus.
module apa102_in #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int TIMEOUT_BITS      = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    input  logic                         data_in,
    input  logic                         clock_in,
    apa102_in_if.master                  bus,
    output logic                         frame_done_strobe,
    output logic [ADDRESS_BUS_WIDTH-1:0] led_count,
    output logic                         overflow,
    output logic                         busy
);
    localparam int AW = ADDRESS_BUS_WIDTH;

    typedef enum logic [1:0] {HUNT = 2'd0, SYNCED = 2'd1, FRAME = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic                      data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic                      clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic [5:0]                zero_count_q, zero_count_d;
    logic [4:0]                bit_count_q, bit_count_d;
    logic [31:0]               frame_q, frame_d;
    logic [AW-1:0]             led_index_q, led_index_d;
    logic [TIMEOUT_BITS-1:0]   timeout_q, timeout_d;
    logic [AW-1:0]             write_address_q, write_address_d;
    logic [DATA_BUS_WIDTH-1:0] write_data_q, write_data_d;
    logic                      write_strobe_q, write_strobe_d;
    logic                      done_q, done_d;
    logic [AW-1:0]             led_count_q, led_count_d;
    logic                      overflow_q, overflow_d;
    logic                      busy_q, busy_d;

    logic          rise_s, bit_s, fits_s;
    logic [31:0]   shifted_s;
    logic [AW+1:0] need_s;
    logic [AW-1:0] word0_addr_s, word1_addr_s;

    assign rise_s       = clk_s2_q & ~clk_prev_q;
    assign bit_s        = data_s2_q;
    assign shifted_s    = {frame_q[30:0], bit_s};
    // Extra headroom bits keep 2*led_index+2 from wrapping before the compare.
    assign need_s       = {1'b0, led_index_q, 1'b0} + {{AW{1'b0}}, 2'b10};
    assign fits_s       = need_s <= {2'b00, word_count};
    assign word0_addr_s = start_address + {led_index_q[AW-2:0], 1'b0};
    assign word1_addr_s = word0_addr_s + {{(AW-1){1'b0}}, 1'b1};

    // Framing FSM, idle timeout and write/packet output generation.
    always_comb begin
        state_d         = state_q;
        data_s1_d       = data_in;
        data_s2_d       = data_s1_q;
        clk_s1_d        = clock_in;
        clk_s2_d        = clk_s1_q;
        clk_prev_d      = clk_s2_q;
        zero_count_d    = zero_count_q;
        bit_count_d     = bit_count_q;
        frame_d         = frame_q;
        led_index_d     = led_index_q;
        timeout_d       = timeout_q + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        write_strobe_d  = 1'b0;
        done_d          = 1'b0;
        led_count_d     = led_count_q;
        overflow_d      = overflow_q;

        if (rise_s) begin
            timeout_d = {TIMEOUT_BITS{1'b0}};
            case (state_q)
                HUNT: begin
                    if (!bit_s) begin
                        if (zero_count_q == 6'd31) begin
                            state_d      = SYNCED;
                            zero_count_d = 6'd0;
                            led_index_d  = {AW{1'b0}};
                            overflow_d   = 1'b0;
                        end else begin
                            zero_count_d = zero_count_q + 6'd1;
                        end
                    end else begin
                        zero_count_d = 6'd0;
                    end
                end
                SYNCED: begin
                    if (bit_s) begin
                        state_d     = FRAME;
                        bit_count_d = 5'd1;
                        frame_d     = shifted_s;
                    end else begin
                        state_d = SYNCED;
                    end
                end
                FRAME: begin
                    frame_d     = shifted_s;
                    bit_count_d = bit_count_q + 5'd1;
                    if (bit_count_q == 5'd15) begin
                        if ((shifted_s[15:13] == 3'b111) && fits_s) begin
                            write_strobe_d  = 1'b1;
                            write_address_d = word0_addr_s;
                            write_data_d    = shifted_s[15:0];
                        end else begin
                            write_strobe_d = 1'b0;
                        end
                    end else if (bit_count_q == 5'd31) begin
                        if (shifted_s[31:29] == 3'b111) begin
                            if (fits_s) begin
                                write_strobe_d  = 1'b1;
                                write_address_d = word1_addr_s;
                                write_data_d    = shifted_s[15:0];
                            end else begin
                                overflow_d = 1'b1;
                            end
                            led_index_d = led_index_q + {{(AW-1){1'b0}}, 1'b1};
                        end else if (shifted_s == 32'd0) begin
                            done_d      = 1'b1;
                            led_count_d = led_index_q;
                            state_d     = SYNCED;
                            led_index_d = {AW{1'b0}};
                            overflow_d  = 1'b0;
                        end else begin
                            done_d      = 1'b1;
                            led_count_d = led_index_q;
                            state_d     = HUNT;
                            led_index_d = {AW{1'b0}};
                        end
                    end else begin
                        write_strobe_d = 1'b0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (&timeout_q) begin
            timeout_d = {TIMEOUT_BITS{1'b0}};
            if (state_q == HUNT) begin
                zero_count_d = 6'd0;
            end else begin
                done_d      = 1'b1;
                led_count_d = led_index_q;
                state_d     = HUNT;
                bit_count_d = 5'd0;
                led_index_d = {AW{1'b0}};
            end
        end else begin
            timeout_d = timeout_q + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
        end

        busy_d = (state_d != HUNT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= HUNT;
            data_s1_q       <= 1'b0;
            data_s2_q       <= 1'b0;
            clk_s1_q        <= 1'b0;
            clk_s2_q        <= 1'b0;
            clk_prev_q      <= 1'b0;
            zero_count_q    <= 6'd0;
            bit_count_q     <= 5'd0;
            frame_q         <= 32'd0;
            led_index_q     <= {AW{1'b0}};
            timeout_q       <= {TIMEOUT_BITS{1'b0}};
            write_address_q <= {AW{1'b0}};
            write_data_q    <= {DATA_BUS_WIDTH{1'b0}};
            write_strobe_q  <= 1'b0;
            done_q          <= 1'b0;
            led_count_q     <= {AW{1'b0}};
            overflow_q      <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            data_s1_q       <= data_s1_d;
            data_s2_q       <= data_s2_d;
            clk_s1_q        <= clk_s1_d;
            clk_s2_q        <= clk_s2_d;
            clk_prev_q      <= clk_prev_d;
            zero_count_q    <= zero_count_d;
            bit_count_q     <= bit_count_d;
            frame_q         <= frame_d;
            led_index_q     <= led_index_d;
            timeout_q       <= timeout_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_strobe_q  <= write_strobe_d;
            done_q          <= done_d;
            led_count_q     <= led_count_d;
            overflow_q      <= overflow_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.write_address  = write_address_q;
    assign bus.write_data     = write_data_q;
    assign bus.write_strobe   = write_strobe_q;
    assign frame_done_strobe  = done_q;
    assign led_count          = led_count_q;
    assign overflow           = overflow_q;
    assign busy               = busy_q;
endmodule

// File: tb/tb_apa102_in.sv
// Bench for apa102_in: table of single-packet vectors plus hand-written
// sequences; writes and packet ends are checked against queued expectations.
module tb_apa102_in;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] start_address = 16'h0000;
    logic [15:0] word_count = 16'h0000;
    logic        data_in = 1'b0;
    logic        clock_in = 1'b0;
    logic        frame_done_strobe;
    logic [15:0] led_count;
    logic        overflow;
    logic        busy;

    apa102_in_if bus_if ();

    apa102_in dut (
        .clk               (clk),
        .rst               (rst),
        .start_address     (start_address),
        .word_count        (word_count),
        .data_in           (data_in),
        .clock_in          (clock_in),
        .bus               (bus_if.master),
        .frame_done_strobe (frame_done_strobe),
        .led_count         (led_count),
        .overflow          (overflow),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic [15:0]       sa;
        logic [15:0]       wc;
        int                n;
        logic [3:0][31:0]  f;
        int                hi;
        int                lo;
        logic [15:0]       exp_lc;
        logic              exp_ov;
    } vec_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_done[$];
    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        clock_in = 1'b0;
        data_in  = b;
        cyc(lo);
        clock_in = 1'b1;
        cyc(hi);
    endtask

    task automatic send_word(input logic [31:0] w, input int hi, input int lo);
        for (int i = 31; i >= 0; i--) send_bit(w[i], hi, lo);
        clock_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clock_in = 1'b0;
        data_in = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic wait_done(input string name, input int mark);
        int n = 0;
        while (done_seen == mark && n < 6000) begin
            cyc(1);
            n++;
        end
        if (done_seen == mark) begin
            checks++;
            failures++;
            $display("FAIL %s no frame_done_strobe within 6000 cycles", name);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, {16'h0, bus_if.write_address}, 32'h0);
        check({tag, "_data"}, {16'h0, bus_if.write_data}, 32'h0);
        check({tag, "_strobe"}, {31'h0, bus_if.write_strobe}, 32'h0);
        check({tag, "_done"}, {31'h0, frame_done_strobe}, 32'h0);
        check({tag, "_led_count"}, {16'h0, led_count}, 32'h0);
        check({tag, "_overflow"}, {31'h0, overflow}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    // Scoreboard monitor: every write and packet end must match a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.write_strobe) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h", bus_if.write_address, bus_if.write_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write", {bus_if.write_address, bus_if.write_data}, {e.a, e.d});
                end
            end
            if (frame_done_strobe) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done led_count=%0d", led_count);
                end else begin
                    logic [15:0] lc;
                    lc = exp_done.pop_front();
                    check("done_led_count", {16'h0, led_count}, {16'h0, lc});
                end
            end
        end
    end

    initial begin
        vec_t        vecs[5];
        int          mark;
        logic [31:0] w;

        vecs[0] = '{16'h0100, 16'd8, 1, {32'h0, 32'h0, 32'h0, 32'hE1123456}, 4, 4, 16'd1, 1'b0};
        vecs[1] = '{16'h0100, 16'd4, 3, {32'h0, 32'hE0ABCDEF, 32'hFF00FF00, 32'hE1112222}, 4, 4, 16'd3, 1'b1};
        vecs[2] = '{16'hFFFF, 16'd8, 1, {32'h0, 32'h0, 32'h0, 32'hE5A5A5A5}, 4, 4, 16'd1, 1'b0};
        vecs[3] = '{16'h0200, 16'd0, 2, {32'h0, 32'h0, 32'hE2222222, 32'hE1111111}, 4, 4, 16'd2, 1'b1};
        vecs[4] = '{16'h0300, 16'd8, 2, {32'h0, 32'h0, 32'hF5555555, 32'hEAAAAAAA}, 3, 3, 16'd2, 1'b0};

        do_reset();
        check_idle_outputs("reset");

        for (int v = 0; v < 5; v++) begin
            do_reset();
            start_address = vecs[v].sa;
            word_count    = vecs[v].wc;
            for (int i = 0; i < vecs[v].n; i++) begin
                if (2 * i + 2 <= int'(vecs[v].wc)) begin
                    w = vecs[v].f[i];
                    exp_wr.push_back('{vecs[v].sa + 16'(2 * i), w[31:16]});
                    exp_wr.push_back('{vecs[v].sa + 16'(2 * i + 1), w[15:0]});
                end
            end
            send_word(32'h0, vecs[v].hi, vecs[v].lo);
            cyc(2);
            check($sformatf("vec%0d_busy_synced", v), {31'h0, busy}, 32'h1);
            for (int i = 0; i < vecs[v].n; i++) send_word(vecs[v].f[i], vecs[v].hi, vecs[v].lo);
            exp_done.push_back(vecs[v].exp_lc);
            mark = done_seen;
            wait_done($sformatf("vec%0d_timeout", v), mark);
            cyc(2);
            check($sformatf("vec%0d_overflow", v), {31'h0, overflow}, {31'h0, vecs[v].exp_ov});
            check($sformatf("vec%0d_led_count", v), {16'h0, led_count}, {16'h0, vecs[v].exp_lc});
            check($sformatf("vec%0d_busy_end", v), {31'h0, busy}, 32'h0);
            check($sformatf("vec%0d_writes_left", v), exp_wr.size(), 32'd0);
        end

        // Back-to-back packets; second start frame clears overflow.
        do_reset();
        start_address = 16'h0100;
        word_count    = 16'd2;
        exp_wr.push_back('{16'h0100, 16'hE111});
        exp_wr.push_back('{16'h0101, 16'h2222});
        send_word(32'h0, 4, 4);
        send_word(32'hE1112222, 4, 4);
        send_word(32'hE3334444, 4, 4);
        cyc(2);
        check("b2b_overflow_set", {31'h0, overflow}, 32'h1);
        exp_done.push_back(16'd2);
        mark = done_seen;
        send_word(32'h0, 4, 4);
        wait_done("b2b_first_done", mark);
        cyc(2);
        check("b2b_overflow_cleared", {31'h0, overflow}, 32'h0);
        check("b2b_busy_synced", {31'h0, busy}, 32'h1);
        exp_wr.push_back('{16'h0100, 16'hE555});
        exp_wr.push_back('{16'h0101, 16'h6666});
        send_word(32'hE5556666, 4, 4);
        exp_done.push_back(16'd1);
        mark = done_seen;
        wait_done("b2b_second_done", mark);
        cyc(2);
        check("b2b_led_count", {16'h0, led_count}, 32'd1);
        check("b2b_writes_left", exp_wr.size(), 32'd0);

        // Invalid header ends the packet and drops back to HUNT.
        do_reset();
        start_address = 16'h0100;
        word_count    = 16'd8;
        send_word(32'h0, 4, 4);
        exp_done.push_back(16'd0);
        mark = done_seen;
        send_word(32'hBFFFFFFF, 4, 4);
        wait_done("bad_hdr_done", mark);
        cyc(2);
        check("bad_hdr_busy", {31'h0, busy}, 32'h0);
        send_word(32'hE1123456, 4, 4);
        cyc(5000);
        check("bad_hdr_busy_after", {31'h0, busy}, 32'h0);
        check("bad_hdr_writes_left", exp_wr.size(), 32'd0);
        check("bad_hdr_done_left", exp_done.size(), 32'd0);

        // Reset at bit 20 of a frame: word0 already out, nothing further.
        do_reset();
        start_address = 16'h0100;
        word_count    = 16'd8;
        send_word(32'h0, 4, 4);
        exp_wr.push_back('{16'h0100, 16'hE112});
        w = 32'hE1123456;
        for (int i = 31; i >= 12; i--) send_bit(w[i], 4, 4);
        clock_in = 1'b0;
        cyc(4);
        check("midrst_word0_seen", exp_wr.size(), 32'd0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check_idle_outputs("midrst");
        for (int i = 11; i >= 0; i--) send_bit(w[i], 4, 4);
        clock_in = 1'b0;
        cyc(5000);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done_left", exp_done.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
